// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_adder_pkg;

    // Controller states, shared with the serial subtractor family.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used by the serial adder datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    // Purely combinational sum and carry for one bit position.
    always_comb begin
        sum   = a ^ b ^ c_in;
        c_out = (a & b) | (a & c_in) | (b & c_in);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, through a single
// full-adder cell with a registered carry. Done pulses once per result.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    full_adder u_fa (
        .a     (opa_q[0]),
        .b     (opb_q[0]),
        .c_in  (carry_q),
        .sum   (fa_s),
        .c_out (fa_co)
    );

    // Next accumulator value: new sum bit enters at the MSB end.
    always_comb begin
        acc_d    = {fa_s, acc_q[WIDTH-1:1]};
        last_bit = (count_q == LAST);
    end

    // Controller, shift registers, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b;
                        carry_q <= c_in;
                        count_q <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    carry_q <= fa_co;
                    count_q <= count_q + CW'(1);
                    if (last_bit) begin
                        sum_q   <= acc_d;
                        c_out_q <= fa_co;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed checks for serial_adder at WIDTH=8 plus an exhaustive WIDTH=4 sweep.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       c_in4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       c_out4;

    int checks;
    int passes;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(c_in4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one WIDTH=8 add; report edges from accept to done (-1 on timeout).
    task automatic run_add(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                           output int lat, output logic [7:0] s, output logic co);
        a = ia; b = ib; c_in = ic; start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        s = 'x;
        co = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (done) begin
                lat = k;
                s = sum;
                co = c_out;
                break;
            end
        end
    endtask

    // Launch one WIDTH=4 add on the second instance.
    task automatic run_add4(input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                            output int lat, output logic [3:0] s, output logic co);
        a4 = ia; b4 = ib; c_in4 = ic; start4 = 1'b1;
        step();
        start4 = 1'b0;
        lat = -1;
        s = 'x;
        co = 1'bx;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (done4) begin
                lat = k;
                s = sum4;
                co = c_out4;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({busy, done, sum, c_out} !== 11'd0)
            $display("FAIL reset8: got busy=%b done=%b sum=%h c_out=%b, want all 0", busy, done, sum, c_out);
        else passes++;
        checks++;
        if ({busy4, done4, sum4, c_out4} !== 7'd0)
            $display("FAIL reset4: got busy=%b done=%b sum=%h c_out=%b, want all 0", busy4, done4, sum4, c_out4);
        else passes++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat; logic [7:0] s; logic co;
        run_add(8'h5A, 8'h3C, 1'b0, lat, s, co);
        checks++;
        if (lat !== 8 || s !== 8'h96 || co !== 1'b0)
            $display("FAIL basic_5a_3c: got lat=%0d sum=%h c_out=%b, want lat=8 sum=96 c_out=0", lat, s, co);
        else passes++;
        step();
        checks++;
        if (done !== 1'b0 || sum !== 8'h96 || busy !== 1'b0)
            $display("FAIL done_pulse: got done=%b busy=%b sum=%h, want done=0 busy=0 sum=96", done, busy, sum);
        else passes++;
    endtask

    task automatic test_carry();
        int lat; logic [7:0] s; logic co;
        run_add(8'hFF, 8'h01, 1'b0, lat, s, co);
        checks++;
        if (lat !== 8 || s !== 8'h00 || co !== 1'b1)
            $display("FAIL carry_ff_01: got lat=%0d sum=%h c_out=%b, want lat=8 sum=00 c_out=1", lat, s, co);
        else passes++;
        step();
        run_add(8'hFF, 8'hFF, 1'b1, lat, s, co);
        checks++;
        if (lat !== 8 || s !== 8'hFF || co !== 1'b1)
            $display("FAIL carry_ff_ff_1: got lat=%0d sum=%h c_out=%b, want lat=8 sum=ff c_out=1", lat, s, co);
        else passes++;
        step();
    endtask

    task automatic test_ignore_busy();
        int ndone;
        int bad;
        a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        a = 8'hEE; b = 8'hEE; c_in = 1'b1;
        checks++;
        if (busy !== 1'b1) $display("FAIL ignore_accept_busy: got busy=%b, want 1", busy);
        else passes++;
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) begin
                start = 1'b1; a = 8'h10; b = 8'h10;
            end
            step();
            start = 1'b0;
            if (k < 8 && (busy !== 1'b1 || done !== 1'b0)) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL ignore_busy_window: got %0d bad cycles, want 0", bad);
        else passes++;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h02 || c_out !== 1'b0)
            $display("FAIL ignore_result: got done=%b busy=%b sum=%h c_out=%b, want done=1 busy=0 sum=02 c_out=0", done, busy, sum, c_out);
        else passes++;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) $display("FAIL ignore_no_second: got %0d active cycles, want 0", ndone);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] s; logic co;
        run_add(8'h0F, 8'h01, 1'b0, lat, s, co);
        checks++;
        if (lat !== 8 || s !== 8'h10 || co !== 1'b0)
            $display("FAIL b2b_first: got lat=%0d sum=%h c_out=%b, want lat=8 sum=10 c_out=0", lat, s, co);
        else passes++;
        // Start issued during the done cycle.
        run_add(8'h20, 8'h22, 1'b0, lat, s, co);
        checks++;
        if (lat !== 8 || s !== 8'h42 || co !== 1'b0)
            $display("FAIL b2b_second: got lat=%0d sum=%h c_out=%b, want lat=8 sum=42 c_out=0", lat, s, co);
        else passes++;
        step();
    endtask

    task automatic test_reset_midrun();
        int nact;
        int lat; logic [7:0] s; logic co;
        a = 8'hAA; b = 8'h55; c_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, c_out} !== 11'd0)
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h c_out=%b, want all 0", busy, done, sum, c_out);
        else passes++;
        step();
        rst = 1'b0;
        nact = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) nact++;
        end
        checks++;
        if (nact != 0) $display("FAIL midrun_no_done: got %0d active cycles, want 0", nact);
        else passes++;
        run_add(8'h03, 8'h04, 1'b0, lat, s, co);
        checks++;
        if (lat !== 8 || s !== 8'h07 || co !== 1'b0)
            $display("FAIL midrun_next: got lat=%0d sum=%h c_out=%b, want lat=8 sum=07 c_out=0", lat, s, co);
        else passes++;
        step();
    endtask

    task automatic test_sweep4();
        int lat; logic [3:0] s; logic co;
        logic [4:0] want;
        for (int unsigned ia = 0; ia < 16; ia++) begin
            for (int unsigned ib = 0; ib < 16; ib++) begin
                for (int unsigned ic = 0; ic < 2; ic++) begin
                    want = 5'(ia + ib + ic);
                    run_add4(4'(ia), 4'(ib), 1'(ic), lat, s, co);
                    checks++;
                    if (lat !== 4 || {co, s} !== want)
                        $display("FAIL sweep4 %0d+%0d+%0d: got lat=%0d {c_out,sum}=%h, want lat=4 %h", ia, ib, ic, lat, {co, s}, want);
                    else passes++;
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; c_in4 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_busy();
        test_back_to_back();
        test_reset_midrun();
        test_sweep4();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
